mac_accum: RTL
==============

MAC_ACCUM -- requirements
Module: mac_accum

Interface
REQ-001 SHALL have parameter MW, default 33, signed product input width matching the upstream pre-add multiplier output (AW+1+BW with AW=BW=16).
REQ-002 SHALL have parameter NACC, default 8, number of products accumulated per result; legal range 1..256.
REQ-003 SHALL have parameter SHIFT, default 16, right-shift applied at rounding; legal range 1..(AccW-1).
REQ-004 SHALL have parameter OW, default 16, signed output width.
REQ-005 SHALL derive AccW = MW + $clog2(NACC) (MW when NACC=1) as the accumulator width.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 clr  input  1  synchronous clear, abandons the current frame.
REQ-009 in_valid  input  1  in_data holds a valid product.
REQ-010 in_data  input  MW  signed product from upstream multiplier.
REQ-011 in_ready  output  1  block accepts in_data this cycle.
REQ-012 out_valid  output  1  out_data/out_sat hold a result.
REQ-013 out_data  output  OW  signed rounded, saturated accumulation.
REQ-014 out_sat  output  1  result was clipped.
REQ-015 out_ready  input  1  downstream accepts the result.

Function
REQ-016 SHALL accept a sample only on the cycle where in_valid && in_ready.
REQ-017 SHALL use FSM states ACC and HOLD; ACC is the reset state.
REQ-018 In ACC: in_ready=1; the first accepted sample of a frame SHALL load acc = sign-extended in_data; later samples SHALL add; a sample counter SHALL count 0..NACC-1.
REQ-019 On the NACC-th accepted sample, the block SHALL register round_sat(acc + in_data) into out_data/out_sat, set out_valid=1 on the next edge, reset the counter to 0 and enter HOLD; latency from last sample to out_valid SHALL be 1 cycle.
REQ-020 In HOLD: in_ready = out_ready; out_data/out_sat SHALL remain stable until out_valid && out_ready.
REQ-021 On out_valid && out_ready without a simultaneous accepted sample: out_valid=0 and the block enters ACC.
REQ-022 On out_valid && out_ready with a simultaneous accepted sample: the sample SHALL load as sample 1 of the next frame (counter=1), giving zero-bubble streaming.
REQ-023 With NACC=1, every accepted sample SHALL produce a result; the block toggles between ACC and HOLD, or stays in HOLD under continuous out_ready.
REQ-024 Rounding SHALL be round-half-up: r = (x + 2^(SHIFT-1)) >>> SHIFT (arithmetic), computed at AccW+1 bits without overflow.
REQ-025 Saturation SHALL clip r to [-2^(OW-1), 2^(OW-1)-1] and set out_sat=1 only when clipping occurs.
REQ-026 clr SHALL set acc=0, counter=0, out_valid=0, out_sat=0, state=ACC on the next edge, overriding all other events in that cycle.
REQ-027 Accumulation SHALL be exact (no wrap) for any NACC samples of any MW-bit value.

Reset
REQ-028 While rst_n=0: out_valid=0, out_data=0, out_sat=0, acc=0, counter=0, state=ACC, in_ready=1; reset asserted mid-frame SHALL discard the partial frame.
REQ-029 After rst_n deassertion, the first accepted sample SHALL start a new frame.

Structure
REQ-030 Shared package mac_accum_pkg SHALL hold the FSM state enum (ACC, HOLD) and the default parameter constants.
REQ-031 Rounding and saturation SHALL be a separate combinational sub-module round_sat (params IW, SHIFT, OW; ports din, dout, sat).

Verification (NACC=8, SHIFT=16, OW=16, MW=33)
REQ-032 8 samples of 65536, out_ready=1 -> one result: out_data=8, out_sat=0, out_valid 1 cycle after the 8th sample.
REQ-033 8 samples of -32768 -> out_data=-4 (the -4.0 result is exact; -3.5 after the half-LSB offset floors to -4), out_sat=0.
REQ-034 8 samples of 2^31 -> out_data=32767, out_sat=1; 8 samples of -2^32 -> out_data=-32768, out_sat=1.
REQ-035 Result produced, out_ready=0 for 5 cycles, in_valid held 1 -> in_ready=0 and out_data stable for those cycles; no sample lost; next frame's result correct.
REQ-036 16 back-to-back samples of 65536, out_ready=1 -> two results of 8, in_ready never drops.
REQ-037 rst_n pulsed low after 3 samples of 2^31, then 8 samples of 65536 -> out_data=8, out_sat=0; clr after 5 samples gives the same result.

Source files
------------

// File: rtl/mac_accum_pkg.sv
// rtl/mac_accum_pkg.sv - shared FSM state type and default parameters for mac_accum
package mac_accum_pkg;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int DEF_MW    = 33;
  localparam int DEF_NACC  = 8;
  localparam int DEF_SHIFT = 16;
  localparam int DEF_OW    = 16;

endpackage

// File: rtl/mac_accum_round_sat.sv
// rtl/mac_accum_round_sat.sv - round-half-up right shift followed by signed saturation
module round_sat #(
  parameter int IW    = 36,
  parameter int SHIFT = 16,
  parameter int OW    = 16
) (
  input  logic signed [IW-1:0] din,
  output logic signed [OW-1:0] dout,
  output logic                 sat
);

  localparam logic signed [IW:0] HALF = {{IW{1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [IW:0] MAXV = {{(IW - OW + 2){1'b0}}, {(OW - 1){1'b1}}};
  localparam logic signed [IW:0] MINV = {{(IW - OW + 2){1'b1}}, {(OW - 1){1'b0}}};

  // One guard bit keeps the half-LSB offset from overflowing the accumulator range.
  logic signed [IW:0] ext;
  logic signed [IW:0] r;

  always_comb begin
    ext  = {din[IW-1], din};
    r    = (ext + HALF) >>> SHIFT;
    sat  = 1'b0;
    dout = r[OW-1:0];
    if (r > MAXV) begin
      dout = MAXV[OW-1:0];
      sat  = 1'b1;
    end else if (r < MINV) begin
      dout = MINV[OW-1:0];
      sat  = 1'b1;
    end
  end

endmodule

// File: rtl/mac_accum.sv
// rtl/mac_accum.sv - accumulates NACC signed products per frame, emits a rounded saturated result
module mac_accum
  import mac_accum_pkg::*;
#(
  parameter int MW    = DEF_MW,
  parameter int NACC  = DEF_NACC,
  parameter int SHIFT = DEF_SHIFT,
  parameter int OW    = DEF_OW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 in_valid,
  input  logic signed [MW-1:0] in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic signed [OW-1:0] out_data,
  output logic                 out_sat,
  input  logic                 out_ready
);

  localparam int ACCW = MW + $clog2(NACC);
  localparam int CW   = (NACC > 1) ? $clog2(NACC) : 1;
  localparam logic [CW-1:0] LAST = CW'(NACC - 1);

  state_t                 state, state_nx;
  logic signed [ACCW-1:0] acc;
  logic signed [ACCW-1:0] sum;
  logic [CW-1:0]          cnt;
  logic                   take;
  logic                   last;
  logic signed [OW-1:0]   rs_data;
  logic                   rs_sat;

  assign take = in_valid && in_ready;
  assign last = (cnt == LAST);
  // Counter at zero means a new frame: the sample loads instead of adding.
  assign sum  = ((cnt == '0) ? '0 : acc) + ACCW'(in_data);

  round_sat #(
    .IW   (ACCW),
    .SHIFT(SHIFT),
    .OW   (OW)
  ) u_round_sat (
    .din (sum),
    .dout(rs_data),
    .sat (rs_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACC;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ACC:     if (take && last) state_nx = HOLD;
      HOLD:    if (out_ready && !(take && last)) state_nx = ACC;
      default: state_nx = ACC;
    endcase
    if (clr) state_nx = ACC;
  end

  always_comb begin
    in_ready  = (state == ACC) || out_ready;
    out_valid = (state == HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      cnt      <= '0;
      out_data <= '0;
      out_sat  <= 1'b0;
    end else if (clr) begin
      acc     <= '0;
      cnt     <= '0;
      out_sat <= 1'b0;
    end else if (take) begin
      if (last) begin
        cnt      <= '0;
        out_data <= rs_data;
        out_sat  <= rs_sat;
      end else begin
        acc <= sum;
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule
